// File: rtl/dig_out_pkg.sv
// Shared definitions for the multi-channel digital output port: register offsets,
// bus FSM states and the channel-index width helper.
package dig_out_pkg;

  localparam logic [2:0] REG_DATA  = 3'd0;
  localparam logic [2:0] REG_SET   = 3'd1;
  localparam logic [2:0] REG_CLR   = 3'd2;
  localparam logic [2:0] REG_TGL   = 3'd3;
  localparam logic [2:0] REG_PULSE = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  // A single channel still needs one address bit for the channel field.
  function automatic int chb_of(input int nch);
    return (nch > 2) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/dig_out_chan.sv
// One output channel: DATA register with SET/CLR/TGL aliases and, when
// DOUT_PULSE_EN is defined, a one-shot pulse mask with a 16-bit down-counter.
module dig_out_chan
  import dig_out_pkg::*;
#(
  parameter int DW        = 8,
  parameter int PULSE_LEN = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr,
  input  logic [2:0]    reg_sel,
  input  logic [DW-1:0] wdat,
  output logic [DW-1:0] data,
  output logic [15:0]   cnt
);

  logic [DW-1:0] base;
  logic [DW-1:0] data_nxt;

`ifdef DOUT_PULSE_EN
  logic [DW-1:0] mask;
  logic [DW-1:0] mask_keep;
  logic [DW-1:0] mask_nxt;
  logic [15:0]   cnt_q;
  logic [15:0]   cnt_nxt;
  logic          expire;
  logic          pulse_wr;

  assign expire   = (cnt_q == 16'd1);
  assign pulse_wr = wr && (reg_sel == REG_PULSE);
  assign cnt      = cnt_q;

  // Expiry clears first; a same-cycle write to the channel then lands on top.
  always_comb begin
    base      = expire ? (data & ~mask) : data;
    mask_keep = expire ? '0 : mask;
    mask_nxt  = pulse_wr ? (mask_keep | wdat) : mask_keep;
    if (pulse_wr) begin
      cnt_nxt = 16'(PULSE_LEN);
    end else if (cnt_q != 16'd0) begin
      cnt_nxt = cnt_q - 16'd1;
    end else begin
      cnt_nxt = cnt_q;
    end
  end

  // Pulse mask and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask  <= '0;
      cnt_q <= 16'd0;
    end else begin
      mask  <= mask_nxt;
      cnt_q <= cnt_nxt;
    end
  end
`else
  assign base = data;
  assign cnt  = 16'd0;
`endif

  // Bus-side update of the DATA register through its aliases.
  always_comb begin
    data_nxt = base;
    if (wr) begin
      case (reg_sel)
        REG_DATA:  data_nxt = wdat;
        REG_SET:   data_nxt = base | wdat;
        REG_CLR:   data_nxt = base & ~wdat;
        REG_TGL:   data_nxt = base ^ wdat;
`ifdef DOUT_PULSE_EN
        REG_PULSE: data_nxt = base | wdat;
`endif
        default:   data_nxt = base;
      endcase
    end else begin
      data_nxt = base;
    end
  end

  // DATA register drives the board output directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
    end else begin
      data <= data_nxt;
    end
  end

endmodule

// File: rtl/dig_out_port_multi.sv
// STB/ACK bus slave with NCH output channels; optional one-shot pulse registers
// are enabled by defining DOUT_PULSE_EN.
module dig_out_port_multi
  import dig_out_pkg::*;
#(
  parameter int NCH         = 3,
  parameter int DW          = 8,
  parameter int WAIT_STATES = 0,
  parameter int PULSE_LEN   = 16
) (
  input  logic              iCLK,
  input  logic              iRSTn,
  input  logic [31:0]       iADR,
  input  logic [31:0]       iDAT,
  output logic [31:0]       oDAT,
  input  logic              iWE,
  input  logic              iSTB,
  output logic              oACK,
  output logic [NCH*DW-1:0] oDOUT
);

  localparam int CHB = chb_of(NCH);

  state_t                     state;
  state_t                     next_state;
  logic [3:0]                 wait_cnt;
  logic [2:0]                 reg_idx;
  logic [CHB-1:0]             ch_idx;
  logic                       ch_valid;
  logic                       reg_mapped;
  logic                       wr_commit;
  logic [NCH-1:0]             chan_wr;
  logic [NCH-1:0][DW-1:0]     chan_data;
  logic [NCH-1:0][15:0]       chan_cnt;
  logic [DW-1:0]              sel_data;
  logic [15:0]                sel_cnt;
  logic [31:0]                rd_val;
  logic                       unused_bits;

  assign reg_idx     = iADR[4:2];
  assign ch_idx      = iADR[5 +: CHB];
  assign ch_valid    = (int'(ch_idx) < NCH);
`ifdef DOUT_PULSE_EN
  assign reg_mapped  = (reg_idx <= REG_PULSE);
`else
  assign reg_mapped  = (reg_idx <= REG_TGL);
`endif
  assign wr_commit   = (state == ST_ACK) && iWE && ch_valid && reg_mapped;
  assign unused_bits = ^{iADR, iDAT, chan_cnt};

  // Bus FSM next state; a dropped strobe in WAIT abandons the request.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (iSTB) begin
          next_state = (WAIT_STATES > 0) ? ST_WAIT : ST_ACK;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!iSTB) begin
          next_state = ST_IDLE;
        end else if (wait_cnt == 4'(WAIT_STATES - 1)) begin
          next_state = ST_ACK;
        end else begin
          next_state = ST_WAIT;
        end
      end
      ST_ACK:  next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // FSM state and wait-state counter.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state    <= ST_IDLE;
      wait_cnt <= 4'd0;
    end else begin
      state    <= next_state;
      wait_cnt <= (state == ST_WAIT) ? (wait_cnt + 4'd1) : 4'd0;
    end
  end

  // Per-channel write strobes and selected-channel read values.
  always_comb begin
    sel_data = '0;
    sel_cnt  = 16'd0;
    for (int c = 0; c < NCH; c++) begin
      chan_wr[c] = wr_commit && (ch_idx == CHB'(c));
      sel_data   = (ch_idx == CHB'(c)) ? chan_data[c] : sel_data;
      sel_cnt    = (ch_idx == CHB'(c)) ? chan_cnt[c]  : sel_cnt;
    end
  end

  // Read mux; PULSE returns the live counter, not DATA.
  always_comb begin
    rd_val = 32'd0;
    if (ch_valid) begin
      case (reg_idx)
        REG_DATA, REG_SET, REG_CLR, REG_TGL: rd_val = 32'(sel_data);
`ifdef DOUT_PULSE_EN
        REG_PULSE: rd_val = {16'h0, sel_cnt};
`endif
        default:   rd_val = 32'd0;
      endcase
    end else begin
      rd_val = 32'd0;
    end
  end

  // Registered handshake outputs, loaded on entry to ACK.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      oACK <= 1'b0;
      oDAT <= 32'd0;
    end else begin
      oACK <= (next_state == ST_ACK);
      oDAT <= ((next_state == ST_ACK) && !iWE) ? rd_val : 32'd0;
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    dig_out_chan #(
      .DW        (DW),
      .PULSE_LEN (PULSE_LEN)
    ) u_chan (
      .clk     (iCLK),
      .rst_n   (iRSTn),
      .wr      (chan_wr[c]),
      .reg_sel (reg_idx),
      .wdat    (iDAT[DW-1:0]),
      .data    (chan_data[c]),
      .cnt     (chan_cnt[c])
    );
  end

  assign oDOUT = chan_data;

endmodule
